// File: rtl/cursor_mover_pkg.sv
// cursor_mover_pkg: shared cursor types, grid size and the wrap-around step helper
// Contents: cursor_dir_t (step direction), repeat_state_t (auto-repeat FSM), GRID_SIZE, step_idx().
package cursor_mover_pkg;

    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} cursor_dir_t;
    typedef enum logic [1:0] {RPT_IDLE, RPT_HOLD, RPT_REPEAT} repeat_state_t;

    localparam int GRID_SIZE = 9;

    // One wrap-around step on a single grid axis; inc=1 moves toward GRID_SIZE-1.
    function automatic logic [3:0] step_idx(input logic [3:0] v, input logic inc);
        return inc ? ((v == 4'(GRID_SIZE - 1)) ? 4'd0 : v + 4'd1)
                   : ((v == 4'd0) ? 4'(GRID_SIZE - 1) : v - 4'd1);
    endfunction

endpackage

// File: rtl/cursor_mover_btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus debounce counter for one raw push-button
// Ports: clk, reset (sync, active-high), raw (async button), level (debounced), press (one-cycle rise event).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Counter tracks consecutive cycles the synchronised input disagrees with the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/cursor_mover.sv
// cursor_mover: turns four raw buttons into a wrapping cursor position on the sudoku grid
// Ports: clk, reset (sync, active-high), btn_up/down/left/right (raw), move_enable,
//        cursor_row/cursor_col (registered 0..GRID_SIZE-1), cursor_moved (one-cycle step strobe).
module cursor_mover
    import cursor_mover_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 7_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       move_enable,
    output logic [3:0] cursor_row,
    output logic [3:0] cursor_col,
    output logic       cursor_moved
);

    localparam int CW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);

    logic [3:0]    w_raw;
    logic [3:0]    w_lvl;
    logic [3:0]    w_prs;
    cursor_dir_t   w_cand;
    cursor_dir_t   w_dir;
    logic          w_cand_press;
    logic          w_leave;
    logic          w_step;

    repeat_state_t r_state;
    cursor_dir_t   r_dir;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_row;
    logic [3:0]    r_col;
    logic          r_moved;

    // Bit order doubles as priority order: index 0 (up) wins.
    assign w_raw = {btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (w_raw[i]),
            .level (w_lvl[i]),
            .press (w_prs[i])
        );
    end

    // The candidate is the highest-priority held button, so any mismatch with the latched
    // direction means either it was released or a higher-priority button took over.
    always_comb begin
        w_cand       = w_lvl[0] ? DIR_UP : w_lvl[1] ? DIR_DOWN : w_lvl[2] ? DIR_LEFT :
                       w_lvl[3] ? DIR_RIGHT : DIR_NONE;
        w_cand_press = w_lvl[0] ? w_prs[0] : w_lvl[1] ? w_prs[1] : w_lvl[2] ? w_prs[2] :
                       w_lvl[3] ? w_prs[3] : 1'b0;
        w_leave      = (r_state != RPT_IDLE) && (w_cand != r_dir);
        w_step       = move_enable && !w_leave &&
                       ((r_state == RPT_IDLE)   ? w_cand_press :
                        (r_state == RPT_HOLD)   ? (r_cnt == CW'(REPEAT_DELAY - 1)) :
                        (r_state == RPT_REPEAT) ? (r_cnt == CW'(REPEAT_PERIOD - 1)) : 1'b0);
        w_dir        = (r_state == RPT_IDLE) ? w_cand : r_dir;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RPT_IDLE;
            r_dir   <= DIR_NONE;
            r_cnt   <= '0;
            r_row   <= 4'd0;
            r_col   <= 4'd0;
            r_moved <= 1'b0;
        end else begin
            r_moved <= w_step;
            if (w_step) begin
                if (w_dir == DIR_UP || w_dir == DIR_DOWN) begin
                    r_row <= step_idx(r_row, w_dir == DIR_DOWN);
                end else begin
                    r_col <= step_idx(r_col, w_dir == DIR_RIGHT);
                end
            end
            if (!move_enable || w_leave) begin
                r_state <= RPT_IDLE;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_state <= (r_state == RPT_IDLE) ? RPT_HOLD : RPT_REPEAT;
                r_dir   <= w_dir;
                r_cnt   <= '0;
            end else if (r_state != RPT_IDLE) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign cursor_row   = r_row;
    assign cursor_col   = r_col;
    assign cursor_moved = r_moved;

endmodule
